// File: rtl/register_file.sv
// Register file with two asynchronous read ports, one write port, an
// optional hard-wired zero register, optional write-to-read forwarding and
// a sequential clear engine that sweeps one register per clock.
module register_file #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             clr_start,
    output logic             busy,
    output logic             wr_err
);

    // Clear engine states; one bit is enough for the two-state sequencer.
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    // Address limits, widened by one bit so that the range test against
    // DEPTH is meaningful even when DEPTH is a power of two.
    localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [0:0]       r_state;
    logic [AW-1:0]    r_clrPtr;
    logic             r_wrErr;

    logic             w_busy;
    logic             w_waddrInRange;
    logic             w_waddrIsZeroReg;
    logic             w_writeAccept;
    logic             w_writeDrop;
    logic [AW-1:0]    w_raddr [2];
    logic [WIDTH-1:0] w_rdata [2];

    assign w_busy = (r_state == CLEAR);
    assign busy   = w_busy;
    assign wr_err = r_wrErr;

    assign w_raddr[0] = raddr_a;
    assign w_raddr[1] = raddr_b;
    assign rdata_a    = w_rdata[0];
    assign rdata_b    = w_rdata[1];

    // Write qualification: a write is only taken while the clear engine is
    // idle, reset is low and the target is a real, writable register.
    always_comb begin
        w_waddrInRange   = ({1'b0, waddr} < DEPTH_EXT);
        w_waddrIsZeroReg = (ZERO_REG != 0) && (waddr == '0);
        w_writeAccept    = we && !rst && !w_busy && w_waddrInRange && !w_waddrIsZeroReg;
        w_writeDrop      = we && !rst && !w_writeAccept;
    end

    // Storage update: reset wipes everything, the clear sweep owns the array
    // while it runs, otherwise an accepted write lands on its target.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_busy) begin
            r_regs[r_clrPtr] <= '0;
        end else if (w_writeAccept) begin
            r_regs[waddr] <= wdata;
        end
    end

    // Clear sequencer: one register per edge from 0 up to DEPTH-1, then back
    // to idle; a start request arriving mid-sweep is simply not looked at.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_clrPtr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (clr_start) begin
                        r_state  <= CLEAR;
                        r_clrPtr <= '0;
                    end
                end
                CLEAR: begin
                    if (r_clrPtr == LAST_PTR) begin
                        r_state  <= IDLE;
                        r_clrPtr <= '0;
                    end else begin
                        r_clrPtr <= r_clrPtr + AW'(1);
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_clrPtr <= '0;
                end
            endcase
        end
    end

    // Dropped-write flag, raised for the single cycle after the attempt.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrErr <= 1'b0;
        end else begin
            r_wrErr <= w_writeDrop;
        end
    end

    // Read ports: out-of-range and the zero register read as 0, a write
    // accepted this cycle is forwarded when enabled, otherwise array contents.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rdata[p] = '0;
            if (({1'b0, w_raddr[p]} < DEPTH_EXT) &&
                !((ZERO_REG != 0) && (w_raddr[p] == '0))) begin
                if ((BYPASS != 0) && w_writeAccept && (w_raddr[p] == waddr)) begin
                    w_rdata[p] = wdata;
                end else begin
                    w_rdata[p] = r_regs[w_raddr[p]];
                end
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: two configurations (16x8 with zero register and
// forwarding, 32x5 without either) driven by directed and random cycles and
// compared against an array-based model of the register file behaviour.
module tb_register_file;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Configuration A: WIDTH=16, DEPTH=8, ZERO_REG=1, BYPASS=1
    logic        aRst, aWe, aClr, aBusy, aWrErr;
    logic [2:0]  aWaddr, aRaddrA, aRaddrB;
    logic [15:0] aWdata, aRdataA, aRdataB;

    // Configuration B: WIDTH=32, DEPTH=5, ZERO_REG=0, BYPASS=0
    logic        bRst, bWe, bClr, bBusy, bWrErr;
    logic [2:0]  bWaddr, bRaddrA, bRaddrB;
    logic [31:0] bWdata, bRdataA, bRdataB;

    register_file #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1), .BYPASS(1)) dutA (
        .clk(clk), .rst(aRst), .we(aWe), .waddr(aWaddr), .wdata(aWdata),
        .raddr_a(aRaddrA), .rdata_a(aRdataA), .raddr_b(aRaddrB), .rdata_b(aRdataB),
        .clr_start(aClr), .busy(aBusy), .wr_err(aWrErr)
    );

    register_file #(.WIDTH(32), .DEPTH(5), .ZERO_REG(0), .BYPASS(0)) dutB (
        .clk(clk), .rst(bRst), .we(bWe), .waddr(bWaddr), .wdata(bWdata),
        .raddr_a(bRaddrA), .rdata_a(bRdataA), .raddr_b(bRaddrB), .rdata_b(bRdataB),
        .clr_start(bClr), .busy(bBusy), .wr_err(bWrErr)
    );

    // Reference model state, one slot per configuration
    int          depthOf [2] = '{8, 5};
    bit          zrOf    [2] = '{1'b1, 1'b0};
    bit          bypOf   [2] = '{1'b1, 1'b0};
    logic [31:0] maskOf  [2] = '{32'h0000FFFF, 32'hFFFFFFFF};
    logic [31:0] mem     [2][8];
    bit          clearing [2];
    int          clearIdx [2];
    bit          expErr   [2];

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit modelAccept(input int d, input bit r, input bit w, input int wa);
        return !r && w && !clearing[d] && (wa < depthOf[d]) && !(zrOf[d] && wa == 0);
    endfunction

    function automatic logic [31:0] modelRead(input int d, input int ra, input bit acc,
                                              input int wa, input logic [31:0] wd);
        if (ra >= depthOf[d]) return 32'h0;
        if (zrOf[d] && ra == 0) return 32'h0;
        if (bypOf[d] && acc && ra == wa) return wd & maskOf[d];
        return mem[d][ra];
    endfunction

    function automatic void modelReset(input int d);
        for (int i = 0; i < 8; i++) mem[d][i] = 32'h0;
        clearing[d] = 1'b0;
        clearIdx[d] = 0;
        expErr[d]   = 1'b0;
    endfunction

    // One clock cycle on configuration d: drive after the falling edge,
    // check outputs, then advance the model across the rising edge.
    task automatic applyStimulus(input int d, input bit r, input bit w, input int wa,
                                 input logic [31:0] wd, input int ra, input int rb, input bit clr);
        bit    acc;
        string pfx;
        pfx = (d == 0) ? "A" : "B";
        if (d == 0) begin
            aRst = r; aWe = w; aWaddr = 3'(wa); aWdata = wd[15:0];
            aRaddrA = 3'(ra); aRaddrB = 3'(rb); aClr = clr;
        end else begin
            bRst = r; bWe = w; bWaddr = 3'(wa); bWdata = wd;
            bRaddrA = 3'(ra); bRaddrB = 3'(rb); bClr = clr;
        end
        #1;
        acc = modelAccept(d, r, w, wa);
        if (d == 0) begin
            checkOutput({pfx, ".rdata_a"}, {16'h0, aRdataA}, modelRead(d, ra, acc, wa, wd));
            checkOutput({pfx, ".rdata_b"}, {16'h0, aRdataB}, modelRead(d, rb, acc, wa, wd));
            checkOutput({pfx, ".busy"},    {31'h0, aBusy},   {31'h0, clearing[d]});
            checkOutput({pfx, ".wr_err"},  {31'h0, aWrErr},  {31'h0, expErr[d]});
        end else begin
            checkOutput({pfx, ".rdata_a"}, bRdataA,          modelRead(d, ra, acc, wa, wd));
            checkOutput({pfx, ".rdata_b"}, bRdataB,          modelRead(d, rb, acc, wa, wd));
            checkOutput({pfx, ".busy"},    {31'h0, bBusy},   {31'h0, clearing[d]});
            checkOutput({pfx, ".wr_err"},  {31'h0, bWrErr},  {31'h0, expErr[d]});
        end
        @(posedge clk);
        if (r) begin
            modelReset(d);
        end else begin
            expErr[d] = w && !acc;
            if (clearing[d]) begin
                mem[d][clearIdx[d]] = 32'h0;
                clearIdx[d]++;
                if (clearIdx[d] == depthOf[d]) clearing[d] = 1'b0;
            end else begin
                if (acc) mem[d][wa] = wd & maskOf[d];
                if (clr) begin
                    clearing[d] = 1'b1;
                    clearIdx[d] = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic randomCycles(input int d, input int n);
        bit          r, w, clr;
        int          wa, ra, rb;
        logic [31:0] wd;
        for (int k = 0; k < n; k++) begin
            r   = ($urandom_range(0, 63) == 0);
            w   = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 15) == 0);
            wa  = $urandom_range(0, 7);
            ra  = $urandom_range(0, 7);
            rb  = (k % 5 == 0) ? ra : $urandom_range(0, 7);
            wd  = $urandom;
            applyStimulus(d, r, w, wa, wd, ra, rb, clr);
        end
    endtask

    initial begin
        aRst = 1'b1; aWe = 1'b0; aWaddr = '0; aWdata = '0; aRaddrA = '0; aRaddrB = '0; aClr = 1'b0;
        bRst = 1'b1; bWe = 1'b0; bWaddr = '0; bWdata = '0; bRaddrA = '0; bRaddrB = '0; bClr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        modelReset(0);
        modelReset(1);
        aRst = 1'b0;
        bRst = 1'b0;

        // Configuration A: reset state, write/readback, forwarding, zero register
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, i, 7 - i, 0);
        applyStimulus(0, 0, 1, 3, 32'hBEEF, 3, 3, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, 3, i, 0);
        applyStimulus(0, 0, 1, 5, 32'h1234, 5, 4, 0);
        applyStimulus(0, 0, 0, 0, 0, 5, 3, 0);
        applyStimulus(0, 0, 1, 0, 32'hFFFF, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 5, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 5, 0);

        // Configuration A: fill, sweep clear with a restart attempt and a dropped write
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, i, 32'h1111 * (i + 1), i, 7 - i, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 7, 1);
        for (int i = 0; i < 10; i++)
            applyStimulus(0, 0, (i == 4), 2, 32'hABCD, i % 8, (i + 4) % 8, (i == 2));

        // Configuration A: write together with clear start, then reset mid-sweep
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, i, 32'hA5A0 + i, i, 0, 0);
        applyStimulus(0, 0, 1, 6, 32'h4321, 6, 6, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 6, 7, 0);
        applyStimulus(0, 1, 1, 6, 32'h5555, 6, 7, 1);
        applyStimulus(0, 0, 1, 6, 32'h7777, 6, 7, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, i, 6, 0);
        randomCycles(0, 300);

        // Configuration B: out-of-range accesses, no forwarding, writable register 0
        applyStimulus(1, 0, 0, 0, 0, 0, 4, 0);
        applyStimulus(1, 0, 1, 6, 32'h12345678, 6, 7, 0);
        applyStimulus(1, 0, 0, 0, 0, 7, 6, 0);
        applyStimulus(1, 0, 1, 4, 32'hDEADBEEF, 4, 4, 0);
        applyStimulus(1, 0, 0, 0, 0, 4, 4, 0);
        applyStimulus(1, 0, 1, 0, 32'hFFFF, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 1, 2, 32'h1234, 2, 2, 0);
        applyStimulus(1, 0, 0, 0, 0, 2, 4, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 4, 1);
        for (int i = 0; i < 7; i++) applyStimulus(1, 0, (i == 3), 1, 32'h99, i % 5, (i + 2) % 5, 0);
        randomCycles(1, 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
